// File: rtl/dice_if_pkg.sv
// Shared types and constants for the image BRAM port scheduler.
// The frame FSM state and the word-to-byte address helper live here.
package dice_if_pkg;

  localparam int         ADDR_W     = 17;
  localparam int         BRAM_W     = 32;
  localparam int         BYTE_SHIFT = 2;
  localparam logic [3:0] WE_ALL     = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRAD   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_GAMMA  = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // 32-bit words: byte address is the word index shifted left by two.
  function automatic logic [BRAM_W-1:0] word_to_byte(input logic [ADDR_W-1:0] i_word);
    return {{(BRAM_W-ADDR_W-BYTE_SHIFT){1'b0}}, i_word, {BYTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/bram_port_scheduler_if.sv
// Engine-side and BRAM-side signal bundle of the port scheduler.
// Handshake: a requester raises *_req and holds it (with its address) until the
// cycle it sees *_gnt; the access happens in the cycle where req and gnt are both high.
interface bram_port_scheduler_if;
  import dice_if_pkg::*;

  logic              frame_start;
  logic              grad_req;
  logic              grad_wr;
  logic [ADDR_W-1:0] grad_addr;
  logic              grad_done;
  logic              grad_gnt;
  logic              gamma_req;
  logic [ADDR_W-1:0] gamma_addr_ref;
  logic [ADDR_W-1:0] gamma_addr_def;
  logic              gamma_done;
  logic              gamma_gnt;
  logic              gamma_rvalid;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [BRAM_W-1:0] bram_addr_ref;
  logic [BRAM_W-1:0] bram_addr_def;
  logic              grad_phase;
  logic              frame_busy;
  logic              frame_done;
  logic [ADDR_W-1:0] wr_count;
  logic              err_overrun;
  logic              err_short;
  state_t            dbg_state;

  modport master (
    input  frame_start, grad_req, grad_wr, grad_addr, grad_done,
           gamma_req, gamma_addr_ref, gamma_addr_def, gamma_done,
    output grad_gnt, gamma_gnt, gamma_rvalid, bram_en, bram_we,
           bram_addr_ref, bram_addr_def, grad_phase, frame_busy,
           frame_done, wr_count, err_overrun, err_short, dbg_state
  );

  modport slave (
    output frame_start, grad_req, grad_wr, grad_addr, grad_done,
           gamma_req, gamma_addr_ref, gamma_addr_def, gamma_done,
    input  grad_gnt, gamma_gnt, gamma_rvalid, bram_en, bram_we,
           bram_addr_ref, bram_addr_def, grad_phase, frame_busy,
           frame_done, wr_count, err_overrun, err_short, dbg_state
  );

endinterface

// File: rtl/rvalid_pipe.sv
// Read-valid tracker: one bit per granted read travels DEPTH stages and
// emerges as read-data-valid; o_empty is high when nothing is in flight.
module rvalid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_valid};
    end
  end

  assign o_valid = r_pipe[DEPTH-1];
  assign o_empty = ~|r_pipe;

endmodule

// File: rtl/bram_port_scheduler.sv
// Frame scheduler sharing the image BRAM port: gradient writes first, then
// gamma ref/def reads, with registered BRAM controls and read-valid tracking.
module bram_port_scheduler
  import dice_if_pkg::*;
#(
  parameter int BRAM_LAT  = 2,
  parameter int PIX_COUNT = 76800
) (
  input  logic                   clock,
  input  logic                   resetn,
  bram_port_scheduler_if.master  bus
);

  localparam logic [ADDR_W-1:0] PIX_W = ADDR_W'(PIX_COUNT);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_grad_gnt;
  logic              w_gamma_gnt;
  logic              w_frame_done;
  logic              w_wr_inc;
  logic [ADDR_W-1:0] w_wr_count_nxt;
  logic              w_rvalid;
  logic              w_pipe_empty;

  logic              r_bram_en;
  logic [3:0]        r_bram_we;
  logic [BRAM_W-1:0] r_addr_ref;
  logic [BRAM_W-1:0] r_addr_def;
  logic [ADDR_W-1:0] r_wr_count;
  logic              r_err_overrun;
  logic              r_err_short;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.frame_start) w_state_nxt = ST_GRAD;
      ST_GRAD:   if (bus.grad_done)   w_state_nxt = ST_SWITCH;
      ST_SWITCH:                      w_state_nxt = ST_GAMMA;
      ST_GAMMA:  if (bus.gamma_done)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_pipe_empty)    w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Grants are combinational so a held request is accepted in its own cycle.
  always_comb begin
    w_grad_gnt   = 1'b0;
    w_gamma_gnt  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_GRAD:  w_grad_gnt   = bus.grad_req;
      ST_GAMMA: w_gamma_gnt  = bus.gamma_req;
      ST_DRAIN: w_frame_done = w_pipe_empty;
      default: ;
    endcase
  end

  always_comb begin
    w_wr_inc       = w_grad_gnt & bus.grad_wr;
    w_wr_count_nxt = r_wr_count;
    if (w_wr_inc && (r_wr_count != '1)) begin
      w_wr_count_nxt = r_wr_count + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bram_en     <= 1'b0;
      r_bram_we     <= '0;
      r_addr_ref    <= '0;
      r_addr_def    <= '0;
      r_wr_count    <= '0;
      r_err_overrun <= 1'b0;
      r_err_short   <= 1'b0;
    end else begin
      r_bram_en <= w_grad_gnt | w_gamma_gnt;
      r_bram_we <= w_wr_inc ? WE_ALL : 4'b0000;

      // Addresses only move on a grant; idle cycles leave the last value on the port.
      if (w_grad_gnt) begin
        r_addr_ref <= word_to_byte(bus.grad_addr);
      end else if (w_gamma_gnt) begin
        r_addr_ref <= word_to_byte(bus.gamma_addr_ref);
        r_addr_def <= word_to_byte(bus.gamma_addr_def);
      end

      if ((r_state == ST_IDLE) && bus.frame_start) begin
        r_wr_count <= '0;
      end else begin
        r_wr_count <= w_wr_count_nxt;
      end

      if (bus.frame_start && (r_state != ST_IDLE)) begin
        r_err_overrun <= 1'b1;
      end

      // The check includes a write granted in the same cycle as grad_done.
      if ((r_state == ST_GRAD) && bus.grad_done && (w_wr_count_nxt != PIX_W)) begin
        r_err_short <= 1'b1;
      end
    end
  end

  rvalid_pipe #(
    .DEPTH (BRAM_LAT + 1)
  ) u_rvalid_pipe (
    .clk     (clock),
    .rst_n   (resetn),
    .i_valid (w_gamma_gnt),
    .o_valid (w_rvalid),
    .o_empty (w_pipe_empty)
  );

  assign bus.grad_gnt      = w_grad_gnt;
  assign bus.gamma_gnt     = w_gamma_gnt;
  assign bus.gamma_rvalid  = w_rvalid;
  assign bus.bram_en       = r_bram_en;
  assign bus.bram_we       = r_bram_we;
  assign bus.bram_addr_ref = r_addr_ref;
  assign bus.bram_addr_def = r_addr_def;
  assign bus.grad_phase    = (r_state == ST_GRAD);
  assign bus.frame_busy    = (r_state != ST_IDLE);
  assign bus.frame_done    = w_frame_done;
  assign bus.wr_count      = r_wr_count;
  assign bus.err_overrun   = r_err_overrun;
  assign bus.err_short     = r_err_short;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Directed bench for bram_port_scheduler: three frames covering writes,
// turnaround, back-to-back reads, drain, overrun and mid-frame reset.
module tb_bram_port_scheduler;
  import dice_if_pkg::*;

  logic clock = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [ADDR_W-1:0] grad_addr_tbl [4];
  logic [31:0]       exp_ref_tbl   [4];

  bram_port_scheduler_if bus ();

  bram_port_scheduler #(
    .BRAM_LAT  (2),
    .PIX_COUNT (76800)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    bus.frame_start    = 1'b0;
    bus.grad_req       = 1'b0;
    bus.grad_wr        = 1'b0;
    bus.grad_addr      = '0;
    bus.grad_done      = 1'b0;
    bus.gamma_req      = 1'b0;
    bus.gamma_addr_ref = '0;
    bus.gamma_addr_def = '0;
    bus.gamma_done     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    grad_addr_tbl[0] = 17'h00000; exp_ref_tbl[0] = 32'h0000_0000;
    grad_addr_tbl[1] = 17'h00001; exp_ref_tbl[1] = 32'h0000_0004;
    grad_addr_tbl[2] = 17'h00002; exp_ref_tbl[2] = 32'h0000_0008;
    grad_addr_tbl[3] = 17'h1FFFF; exp_ref_tbl[3] = 32'h0007_FFFC;

    resetn = 1'b0;
    clear_inputs();
    repeat (2) tick();
    chk("rst_state",   32'(bus.dbg_state), 32'(ST_IDLE));
    chk("rst_en",      32'(bus.bram_en), 32'd0);
    chk("rst_we",      32'(bus.bram_we), 32'd0);
    chk("rst_addr_ref", bus.bram_addr_ref, 32'd0);
    chk("rst_addr_def", bus.bram_addr_def, 32'd0);
    chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
    chk("rst_busy",    32'(bus.frame_busy), 32'd0);
    chk("rst_rvalid",  32'(bus.gamma_rvalid), 32'd0);
    resetn = 1'b1;
    tick();

    // Frame 1: four writes, one read, then gamma reads with reads pending in GRAD.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("f1_state_grad", 32'(bus.dbg_state), 32'(ST_GRAD));
    chk("f1_grad_phase", 32'(bus.grad_phase), 32'd1);
    chk("f1_busy",       32'(bus.frame_busy), 32'd1);
    chk("f1_wr_clear",   32'(bus.wr_count), 32'd0);

    bus.gamma_req      = 1'b1;
    bus.gamma_addr_ref = 17'd5;
    bus.gamma_addr_def = 17'd9;
    for (int i = 0; i < 4; i++) begin
      bus.grad_req  = 1'b1;
      bus.grad_wr   = 1'b1;
      bus.grad_addr = grad_addr_tbl[i];
      #1;
      chk("wr_grad_gnt",  32'(bus.grad_gnt), 32'd1);
      chk("wr_gamma_gnt", 32'(bus.gamma_gnt), 32'd0);
      tick();
      chk("wr_en",       32'(bus.bram_en), 32'd1);
      chk("wr_we",       32'(bus.bram_we), 32'hF);
      chk("wr_addr_ref", bus.bram_addr_ref, exp_ref_tbl[i]);
      chk("wr_addr_def", bus.bram_addr_def, 32'd0);
      chk("wr_count",    32'(bus.wr_count), 32'(i + 1));
    end

    bus.grad_wr   = 1'b0;
    bus.grad_addr = 17'd3;
    #1;
    chk("rd_grad_gnt", 32'(bus.grad_gnt), 32'd1);
    tick();
    chk("rd_en",       32'(bus.bram_en), 32'd1);
    chk("rd_we",       32'(bus.bram_we), 32'd0);
    chk("rd_addr_ref", bus.bram_addr_ref, 32'd12);
    chk("rd_wr_count", 32'(bus.wr_count), 32'd4);

    bus.grad_req = 1'b0;
    tick();
    chk("idle_en",       32'(bus.bram_en), 32'd0);
    chk("idle_we",       32'(bus.bram_we), 32'd0);
    chk("idle_addr_hold", bus.bram_addr_ref, 32'd12);

    bus.grad_done = 1'b1;
    #1;
    chk("done_gamma_gnt", 32'(bus.gamma_gnt), 32'd0);
    tick();
    bus.grad_done = 1'b0;
    chk("sw_state",     32'(bus.dbg_state), 32'(ST_SWITCH));
    chk("sw_err_short", 32'(bus.err_short), 32'd1);
    chk("sw_phase",     32'(bus.grad_phase), 32'd0);
    chk("sw_en",        32'(bus.bram_en), 32'd0);
    #1;
    chk("sw_gamma_gnt", 32'(bus.gamma_gnt), 32'd0);
    tick();

    // Three back-to-back gamma reads; rvalid trails each grant by three cycles.
    chk("g_state", 32'(bus.dbg_state), 32'(ST_GAMMA));
    bus.grad_req = 1'b1;
    #1;
    chk("g0_gamma_gnt", 32'(bus.gamma_gnt), 32'd1);
    chk("g0_grad_gnt",  32'(bus.grad_gnt), 32'd0);
    tick();
    chk("g1_en",       32'(bus.bram_en), 32'd1);
    chk("g1_we",       32'(bus.bram_we), 32'd0);
    chk("g1_addr_ref", bus.bram_addr_ref, 32'd20);
    chk("g1_addr_def", bus.bram_addr_def, 32'd36);
    chk("g1_rvalid",   32'(bus.gamma_rvalid), 32'd0);
    chk("g1_wr_count", 32'(bus.wr_count), 32'd4);
    bus.grad_req    = 1'b0;
    bus.frame_start = 1'b1;
    #1;
    chk("g1_gamma_gnt", 32'(bus.gamma_gnt), 32'd1);
    tick();
    bus.frame_start = 1'b0;
    chk("ovr_state",   32'(bus.dbg_state), 32'(ST_GAMMA));
    chk("ovr_err",     32'(bus.err_overrun), 32'd1);
    chk("g2_rvalid",   32'(bus.gamma_rvalid), 32'd0);
    bus.gamma_done = 1'b1;
    #1;
    chk("g2_gamma_gnt", 32'(bus.gamma_gnt), 32'd1);
    tick();
    bus.gamma_req  = 1'b0;
    bus.gamma_done = 1'b0;
    chk("dr_state",   32'(bus.dbg_state), 32'(ST_DRAIN));
    chk("dr_rvalid0", 32'(bus.gamma_rvalid), 32'd1);
    chk("dr_en",      32'(bus.bram_en), 32'd1);
    chk("dr_done0",   32'(bus.frame_done), 32'd0);
    tick();
    chk("dr_rvalid1", 32'(bus.gamma_rvalid), 32'd1);
    chk("dr_en_off",  32'(bus.bram_en), 32'd0);
    tick();
    chk("dr_rvalid2", 32'(bus.gamma_rvalid), 32'd1);
    chk("dr_done2",   32'(bus.frame_done), 32'd0);
    tick();
    chk("dr_rvalid3", 32'(bus.gamma_rvalid), 32'd0);
    chk("dr_state3",  32'(bus.dbg_state), 32'(ST_DRAIN));
    chk("dr_done3",   32'(bus.frame_done), 32'd1);
    tick();
    chk("end_state",   32'(bus.dbg_state), 32'(ST_IDLE));
    chk("end_done",    32'(bus.frame_done), 32'd0);
    chk("end_busy",    32'(bus.frame_busy), 32'd0);
    chk("end_short",   32'(bus.err_short), 32'd1);
    chk("end_overrun", 32'(bus.err_overrun), 32'd1);

    // Frame 2: reset with a read in flight.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("f2_wr_clear", 32'(bus.wr_count), 32'd0);
    bus.grad_done = 1'b1;
    tick();
    bus.grad_done = 1'b0;
    tick();
    chk("f2_state_gamma", 32'(bus.dbg_state), 32'(ST_GAMMA));
    bus.gamma_req      = 1'b1;
    bus.gamma_addr_ref = 17'h1FFFF;
    bus.gamma_addr_def = 17'd1;
    tick();
    bus.gamma_req = 1'b0;
    chk("f2_addr_ref", bus.bram_addr_ref, 32'h0007_FFFC);
    chk("f2_addr_def", bus.bram_addr_def, 32'd4);
    resetn = 1'b0;
    #1;
    chk("mr_state",    32'(bus.dbg_state), 32'(ST_IDLE));
    chk("mr_en",       32'(bus.bram_en), 32'd0);
    chk("mr_addr_ref", bus.bram_addr_ref, 32'd0);
    chk("mr_addr_def", bus.bram_addr_def, 32'd0);
    chk("mr_short",    32'(bus.err_short), 32'd0);
    chk("mr_overrun",  32'(bus.err_overrun), 32'd0);
    chk("mr_busy",     32'(bus.frame_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_rvalid", 32'(bus.gamma_rvalid), 32'd0);
      chk("mr_done",   32'(bus.frame_done), 32'd0);
    end
    resetn = 1'b1;
    tick();

    // Frame 3: no reads at all, DRAIN lasts exactly one cycle.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.grad_done   = 1'b1;
    tick();
    bus.grad_done = 1'b0;
    tick();
    chk("f3_state_gamma", 32'(bus.dbg_state), 32'(ST_GAMMA));
    bus.gamma_done = 1'b1;
    tick();
    bus.gamma_done = 1'b0;
    chk("f3_state_drain", 32'(bus.dbg_state), 32'(ST_DRAIN));
    chk("f3_done",        32'(bus.frame_done), 32'd1);
    chk("f3_rvalid",      32'(bus.gamma_rvalid), 32'd0);
    chk("f3_short",       32'(bus.err_short), 32'd1);
    tick();
    chk("f3_state_idle",  32'(bus.dbg_state), 32'(ST_IDLE));
    chk("f3_done_off",    32'(bus.frame_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
